// File: rtl/fetch_stage_ifid.sv
// fetch_stage_ifid: PC, ready-handshake instruction fetch and IF/ID register.
// A word fetched during an ID stall waits in a one-entry buffer (HOLD state).
module fetch_stage_ifid #(
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [31:0]           imem_rdata,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic                  if_id_valid,
    output logic [31:0]           if_id_instr,
    output logic [5:0]            if_id_op,
    output logic [5:0]            if_id_funct,
    output logic [ADDR_WIDTH-1:0] if_id_pc_plus4
);
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t state, state_n;
    logic [ADDR_WIDTH-1:0] pc, pc_n, tgt, tgt_n, buf_pc4, buf_pc4_n, pc4, pc4_n, pc_inc, target;
    logic [31:0] buf_instr, buf_instr_n, instr, instr_n;
    logic valid, valid_n;

    assign pc_inc = pc + ADDR_WIDTH'(4);
    assign target = branch_target & ~ADDR_WIDTH'(3);

    assign imem_req = !reset && state != HOLD;
    assign imem_addr = pc;
    assign if_id_valid = valid;
    assign if_id_instr = instr;
    assign if_id_op = instr[31:26];
    assign if_id_funct = instr[5:0];
    assign if_id_pc_plus4 = pc4;

    always_comb begin
        state_n = state;
        pc_n = pc;
        tgt_n = tgt;
        buf_instr_n = buf_instr;
        buf_pc4_n = buf_pc4;
        valid_n = valid;
        instr_n = instr;
        pc4_n = pc4;
        if (branch_taken) begin
            valid_n = 1'b0;
            instr_n = '0;
            // An outstanding request must complete before the PC may move.
            if (state == HOLD || imem_ready) begin
                pc_n = target;
                state_n = FETCH;
            end else begin
                tgt_n = target;
                state_n = DRAIN;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready && !stall) begin
                        valid_n = 1'b1;
                        instr_n = imem_rdata;
                        pc4_n = pc_inc;
                        pc_n = pc_inc;
                    end else if (imem_ready) begin
                        buf_instr_n = imem_rdata;
                        buf_pc4_n = pc_inc;
                        pc_n = pc_inc;
                        state_n = HOLD;
                    end else if (!stall) begin
                        valid_n = 1'b0;
                        instr_n = '0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        valid_n = 1'b1;
                        instr_n = buf_instr;
                        pc4_n = buf_pc4;
                        state_n = FETCH;
                    end
                end
                default: begin
                    if (imem_ready) begin
                        pc_n = tgt;
                        state_n = FETCH;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            pc <= RESET_PC;
            tgt <= '0;
            buf_instr <= '0;
            buf_pc4 <= '0;
            valid <= 1'b0;
            instr <= '0;
            pc4 <= '0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            tgt <= tgt_n;
            buf_instr <= buf_instr_n;
            buf_pc4 <= buf_pc4_n;
            valid <= valid_n;
            instr <= instr_n;
            pc4 <= pc4_n;
        end
    end
endmodule
